// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mips_loader_pkg;

  // Default instruction-memory geometry: 64 words of 32 bits.
  localparam int unsigned IMEM_ADDR_W    = 6;
  localparam int unsigned IMEM_WORDS     = 2 ** IMEM_ADDR_W;

  // Stream framing: 2-byte big-endian word count, then 4 bytes per word.
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    DONE,
    ERR
  } state_e;

endpackage : mips_loader_pkg

// File: rtl/imem_loader.sv
// Loads a byte-streamed program image into instruction RAM and holds the core in reset until done.
// Latency: write strobe one cycle after the 4th byte of a word is accepted; all outputs registered.
// Backpressure: rx_ready high in LEN_HI/LEN_LO/DATA with no bubbles, low in DONE/ERR and during reset.
//
// Ports:
//   CLK, RESET      clock (rising edge) and asynchronous active-low reset
//   rx_data/valid   incoming byte stream; rx_ready accepts (transfer = rx_valid & rx_ready)
//   reload          restart loading, honoured only in DONE
//   mem_we/addr/wdata  one-cycle word write into instruction RAM
//   cpu_reset       active-high core reset, released one cycle after done
//   done, error     image complete / header word count too large
module imem_loader
  import mips_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(2 ** ADDR_W);
  localparam logic [1:0]       BYTE_LAST = 2'(BYTES_PER_WORD - 1);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  // One extra bit so a full 2**ADDR_W word image can be counted.
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         shift_q, shift_d;

  logic                rx_ready_q, rx_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                xfer;
  logic [LEN_W-1:0]    n_len;
  logic [ADDR_W:0]     word_cnt_inc;

  assign xfer         = rx_valid & rx_ready_q;
  assign n_len        = {len_q[LEN_W-1:8], rx_data};
  assign word_cnt_inc = word_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      LEN_HI: begin
        if (xfer) begin
          len_d   = LEN_W'({rx_data, 8'h00});
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d      = n_len;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          if (n_len == '0)            state_d = DONE;
          else if (n_len > MAX_WORDS) state_d = ERR;
          else                        state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], rx_data};
          if (byte_cnt_q == BYTE_LAST) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_cnt_q[ADDR_W-1:0];
            mem_wdata_d = {shift_q, rx_data};
            word_cnt_d  = word_cnt_inc;
            if (LEN_W'(word_cnt_inc) == len_q) state_d = DONE;
          end
        end
      end
      DONE: begin
        if (reload) begin
          state_d    = LEN_HI;
          len_d      = '0;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          shift_d    = '0;
        end
      end
      default: ;  // ERR is sticky until RESET
    endcase

    rx_ready_d  = (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERR);
    // Release the core only once DONE has been held for a cycle, so the
    // final write lands before the first fetch.
    cpu_reset_d = !((state_q == DONE) && (state_d == DONE));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= LEN_HI;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule : imem_loader
